seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/sat_counter.sv | 26 ++
 rtl/seq_detect_param.sv | 85 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: overlap mode encodings
// and the pattern loaded at reset.
package seq_det_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  localparam logic [3:0] PAT_DEFAULT_C = 4'b1101;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Serial MSB-first pattern detector with loadable pattern and overlap select.
// Match counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_C),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_r,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_z;

  logic [PAT_W-1:0]  w_window;
  logic              w_z;
  logic              w_restart;
  mode_e             w_mode;

  // Oldest history bit lines up with pat[PAT_W-1], the live bit with pat[0].
  assign w_window  = {r_hist, x};
  assign w_mode    = mode_e'(overlap);
  assign w_z       = en && !pat_ld && (r_fill == FILL_FULL) && (w_window == r_pat);
  assign w_restart = w_z && (w_mode == MODE_NONOVL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat  <= PAT_DEFAULT;
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else begin
      r_z <= w_z;
      if (pat_ld) begin
        r_pat  <= pat_in;
        r_fill <= '0;
      end else if (en) begin
        if (w_restart) begin
          r_fill <= '0;
        end else begin
          r_hist <= w_window[PAT_W-2:0];
          if (r_fill != FILL_FULL) begin
            r_fill <= r_fill + 1'b1;
          end
        end
      end
    end
  end

  assign z   = w_z;
  assign z_r = r_z;

`ifdef SEQ_DETECT_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_z),
    .clr  (cnt_clr),
    .cnt  (match_cnt)
  );
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign match_cnt    = '0;
`endif

endmodule
